// File: rtl/eaglesong_pkg.sv
// rtl/eaglesong_pkg.sv - shared constants, types and FSM encoding for the Eaglesong sponge controller
//
// Contents:
//   RATE_WORDS, STATE_WORDS  rate and state width in 32-bit words
//   DELIM                    domain delimiter byte appended after the message
//   state_t, digest_t        unpacked word arrays for the full state and the digest
//   sponge_state_t           controller FSM states
package eaglesong_pkg;

  localparam int         RATE_WORDS  = 8;
  localparam int         STATE_WORDS = 16;
  localparam logic [7:0] DELIM       = 8'h06;

  typedef logic [31:0] state_t  [STATE_WORDS];
  typedef logic [31:0] digest_t [RATE_WORDS];

  typedef enum logic [2:0] {
    ABSORB,
    PAD,
    PERM_START,
    PERM_ARM,
    PERM_WAIT,
    OUT
  } sponge_state_t;

endpackage

// File: rtl/eaglesong_pad_word.sv
// rtl/eaglesong_pad_word.sv - last-word byte masker and delimiter inserter
//
// Ports:
//   msg_data    in  32  big-endian message word (byte 0 in [31:24])
//   msg_nbytes  in  3   valid bytes in the word; 4..7 pass the word through unchanged
//   padded      out 32  bytes 0..nbytes-1 kept, DELIM at byte nbytes, rest zero
module eaglesong_pad_word
  import eaglesong_pkg::*;
(
  input  logic [31:0] msg_data,
  input  logic [2:0]  msg_nbytes,
  output logic [31:0] padded
);

  always_comb begin
    padded = msg_data;
    if (msg_nbytes < 3'd4) begin
      for (int b = 0; b < 4; b++) begin
        if (3'(b) < msg_nbytes)
          padded[31-8*b -: 8] = msg_data[31-8*b -: 8];
        else if (3'(b) == msg_nbytes)
          padded[31-8*b -: 8] = DELIM;
        else
          padded[31-8*b -: 8] = 8'h00;
      end
    end
  end

endmodule

// File: rtl/eaglesong_sponge_ctrl.sv
// rtl/eaglesong_sponge_ctrl.sv - Eaglesong sponge absorb/pad/squeeze controller
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   msg_valid/msg_ready        message word handshake; msg_data big-endian,
//   msg_data/msg_last          msg_last marks the final word, msg_nbytes its
//   msg_nbytes                 valid byte count (0..4, larger values act as 4)
//   perm_state_in[16]          current state, presented to the engine
//   perm_start                 one-cycle engine launch pulse
//   perm_state_out[16]         engine result
//   perm_done                  engine result valid (level)
//   digest[8], digest_valid    state words 0..7 after the final permutation
//   digest_ready               digest consumed
//   busy                       low only when idle with an all-zero state
module eaglesong_sponge_ctrl
  import eaglesong_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [31:0] msg_data,
  input  logic        msg_last,
  input  logic [2:0]  msg_nbytes,
  output logic [31:0] perm_state_in [STATE_WORDS],
  output logic        perm_start,
  input  logic [31:0] perm_state_out [STATE_WORDS],
  input  logic        perm_done,
  output logic [31:0] digest [RATE_WORDS],
  output logic        digest_valid,
  input  logic        digest_ready,
  output logic        busy
);

  sponge_state_t fsm, fsm_nxt;
  state_t        state;
  logic [2:0]    idx;
  logic [2:0]    pad_idx;
  logic          final_blk;
  logic          pad_pending;
  logic [31:0]   padded_word;
  logic [31:0]   absorb_word;
  logic          accept;
  logic          short_last;
  logic          full_last;
  logic          state_nz;

  eaglesong_pad_word u_pad (
    .msg_data   (msg_data),
    .msg_nbytes (msg_nbytes),
    .padded     (padded_word)
  );

  // Gated by rst_n so the source sees no ready while reset is held.
  assign msg_ready   = rst_n && (fsm == ABSORB);
  assign accept      = msg_valid && msg_ready;
  assign short_last  = msg_last && (msg_nbytes < 3'd4);
  assign full_last   = msg_last && !short_last;
  // msg_nbytes is meaningless on non-last words, so only the last word is padded.
  assign absorb_word = msg_last ? padded_word : msg_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= ABSORB;
    else        fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt      = fsm;
    perm_start   = 1'b0;
    digest_valid = 1'b0;
    case (fsm)
      ABSORB: begin
        if (accept) begin
          if (short_last)      fsm_nxt = PERM_START;
          else if (full_last)  fsm_nxt = (idx == 3'd7) ? PERM_START : PAD;
          else if (idx == 3'd7) fsm_nxt = PERM_START;
        end
      end
      PAD:        fsm_nxt = PERM_START;
      PERM_START: begin
        perm_start = 1'b1;
        fsm_nxt    = PERM_ARM;
      end
      // The engine's done level is still the previous run's for this cycle.
      PERM_ARM:   fsm_nxt = PERM_WAIT;
      PERM_WAIT: begin
        if (perm_done) begin
          if (final_blk)        fsm_nxt = OUT;
          else if (pad_pending) fsm_nxt = PAD;
          else                  fsm_nxt = ABSORB;
        end
      end
      OUT: begin
        digest_valid = 1'b1;
        if (digest_ready) fsm_nxt = ABSORB;
      end
      default: fsm_nxt = ABSORB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STATE_WORDS; i++) state[i] <= '0;
      idx         <= '0;
      pad_idx     <= '0;
      final_blk   <= 1'b0;
      pad_pending <= 1'b0;
    end else begin
      case (fsm)
        ABSORB: begin
          if (accept) begin
            state[{1'b0, idx}] <= state[{1'b0, idx}] ^ absorb_word;
            idx <= idx + 3'd1;
            if (short_last) final_blk <= 1'b1;
            // A full last word leaves the delimiter for the next rate word,
            // which may fall into a fresh block when this one is full.
            if (full_last) begin
              pad_pending <= 1'b1;
              pad_idx     <= idx + 3'd1;
            end
          end
        end
        PAD: begin
          state[{1'b0, pad_idx}] <= state[{1'b0, pad_idx}] ^ {DELIM, 24'h0};
          pad_pending <= 1'b0;
          final_blk   <= 1'b1;
        end
        PERM_WAIT: begin
          if (perm_done) begin
            state <= perm_state_out;
            idx   <= '0;
          end
        end
        OUT: begin
          if (digest_ready) begin
            for (int i = 0; i < STATE_WORDS; i++) state[i] <= '0;
            final_blk <= 1'b0;
            idx       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign perm_state_in = state;

  always_comb begin
    for (int i = 0; i < RATE_WORDS; i++)
      digest[i] = (fsm == OUT) ? state[i] : 32'h0;
  end

  always_comb begin
    state_nz = 1'b0;
    for (int i = 0; i < STATE_WORDS; i++) state_nz = state_nz | (|state[i]);
  end

  assign busy = (fsm != ABSORB) || (idx != 3'd0) || state_nz;

endmodule

// File: tb/tb_eaglesong_sponge_ctrl.sv
// tb/tb_eaglesong_sponge_ctrl.sv - randomized self-checking bench for eaglesong_sponge_ctrl
`timescale 1ns/1ps
module tb_eaglesong_sponge_ctrl;

  typedef logic [31:0] st_t [16];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        msg_valid;
  logic        msg_ready;
  logic [31:0] msg_data;
  logic        msg_last;
  logic [2:0]  msg_nbytes;
  logic [31:0] perm_state_in [16];
  logic        perm_start;
  logic [31:0] perm_state_out [16] = '{default: 32'hDEADBEEF};
  logic        perm_done = 1'b1;
  logic [31:0] digest [8];
  logic        digest_valid;
  logic        digest_ready;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  // engine stub controls and observations
  int  stale_mode = 0;
  int  lat_force  = 0;
  int  start_cnt  = 0;
  int  stub_k, stub_lat;
  bit  run_active = 0;
  bit  perm_open  = 0;
  bit  rdy_viol;
  st_t stub_cur, pending_res;
  st_t pre_q[$];

  always #5 clk = ~clk;

  eaglesong_sponge_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .msg_valid      (msg_valid),
    .msg_ready      (msg_ready),
    .msg_data       (msg_data),
    .msg_last       (msg_last),
    .msg_nbytes     (msg_nbytes),
    .perm_state_in  (perm_state_in),
    .perm_start     (perm_start),
    .perm_state_out (perm_state_out),
    .perm_done      (perm_done),
    .digest         (digest),
    .digest_valid   (digest_valid),
    .digest_ready   (digest_ready),
    .busy           (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stand-in permutation: any fixed mixing function works for checking the controller.
  function automatic st_t perm_f(input st_t s);
    st_t r;
    logic [31:0] n;
    for (int i = 0; i < 16; i++) begin
      n    = s[(i + 1) % 16];
      r[i] = {n[26:0], n[31:27]} ^ (s[i] * 32'h9E3779B1) ^ (32'h01010101 * 32'(i)) ^ 32'h5A5A0000;
    end
    return r;
  endfunction

  // Sponge reference: pad bytes with 0x06 then zeros to a 32-byte multiple,
  // XOR each block into words 0..7, permute.
  task automatic model(input logic [7:0] m[$], output st_t pres[$], output logic [31:0] dig[8]);
    logic [7:0] pb[$];
    st_t s;
    int nblk;
    pb = m;
    pb.push_back(8'h06);
    while (pb.size() % 32 != 0) pb.push_back(8'h00);
    nblk = pb.size() / 32;
    for (int i = 0; i < 16; i++) s[i] = 32'h0;
    pres.delete();
    for (int b = 0; b < nblk; b++) begin
      for (int w = 0; w < 8; w++)
        s[w] ^= {pb[b*32+4*w], pb[b*32+4*w+1], pb[b*32+4*w+2], pb[b*32+4*w+3]};
      pres.push_back(s);
      s = perm_f(s);
    end
    for (int i = 0; i < 8; i++) dig[i] = s[i];
  endtask

  // Engine stub, updated on the falling edge. In stale mode done stays high
  // with garbage data through the start and arm cycles.
  always @(negedge clk) begin
    if (!rst_n) perm_open = 0;
    if (perm_start) begin
      start_cnt++;
      for (int i = 0; i < 16; i++) stub_cur[i] = perm_state_in[i];
      pre_q.push_back(stub_cur);
      pending_res = perm_f(stub_cur);
      stub_lat    = (lat_force != 0) ? lat_force : int'($urandom_range(1, 5));
      stub_k      = 0;
      run_active  = 1;
      perm_open   = 1;
      rdy_viol    = msg_ready;
      if (stale_mode != 0) begin
        perm_done = 1'b1;
        for (int i = 0; i < 16; i++) perm_state_out[i] = $urandom;
      end else begin
        perm_done = 1'b0;
      end
    end else if (run_active) begin
      stub_k++;
      if (perm_open && msg_ready) rdy_viol = 1;
      if (stale_mode != 0 && stub_k == 2) perm_done = 1'b0;
      if (stub_k == ((stale_mode != 0) ? 2 : 0) + stub_lat) begin
        for (int i = 0; i < 16; i++) perm_state_out[i] = pending_res[i];
        perm_done  = 1'b1;
        run_active = 0;
        if (perm_open) begin
          check("ready_low_during_perm", rdy_viol, 0);
          perm_open = 0;
        end
      end
    end
  end

  // Entered and left on a falling edge.
  task automatic send_beat(input logic [31:0] d, input logic last, input logic [2:0] nb);
    bit r, done;
    msg_valid  = 1'b1;
    msg_data   = d;
    msg_last   = last;
    msg_nbytes = nb;
    done = 0;
    for (int c = 0; c < 4000 && !done; c++) begin
      r = msg_ready;
      @(negedge clk);
      if (r) done = 1;
    end
    if (!done) check("beat_accept_timeout", 0, 1);
  endtask

  task automatic run_msg(input logic [7:0] m[$], input int gap_pct, input int hold, input int bad_nb);
    st_t exp_pre[$];
    logic [31:0] exp_dig[8];
    logic [31:0] w;
    int L, nw, nb, idx, npre;
    pre_q.delete();
    start_cnt = 0;
    model(m, exp_pre, exp_dig);
    L  = m.size();
    nw = (L == 0) ? 1 : (L + 3) / 4;
    for (int wi = 0; wi < nw; wi++) begin
      for (int b = 0; b < 4; b++) begin
        idx = 4 * wi + b;
        w[31-8*b -: 8] = (idx < L) ? m[idx] : 8'($urandom);
      end
      nb = (wi == nw - 1) ? L - 4 * wi : int'($urandom_range(0, 7));
      if (wi == nw - 1 && nb == 4 && bad_nb != 0) begin
        nb = int'($urandom_range(5, 7));
        $display("note: driving illegal msg_nbytes %0d on a full last word", nb);
      end
      if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
        msg_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      send_beat(w, wi == nw - 1, 3'(nb));
    end
    msg_valid = 1'b0;
    for (int c = 0; c < 4000 && !digest_valid; c++) @(negedge clk);
    check("digest_valid_seen", digest_valid, 1);
    if (digest_valid) begin
      for (int h = 0; h < hold; h++) begin
        check("digest_valid_held", digest_valid, 1);
        for (int i = 0; i < 8; i++) check("digest_held", digest[i], exp_dig[i]);
        @(negedge clk);
      end
      for (int i = 0; i < 8; i++) check("digest", digest[i], exp_dig[i]);
      check("busy_in_out", busy, 1);
      check("ready_low_in_out", msg_ready, 0);
      digest_ready = 1'b1;
      @(negedge clk);
      digest_ready = 1'b0;
      check("digest_valid_after_ack", digest_valid, 0);
      check("ready_after_ack", msg_ready, 1);
      check("busy_after_ack", busy, 0);
    end
    check("perm_count", start_cnt, exp_pre.size());
    npre = (pre_q.size() < exp_pre.size()) ? pre_q.size() : exp_pre.size();
    for (int k = 0; k < npre; k++)
      for (int i = 0; i < 16; i++) check("pre_state", pre_q[k][i], exp_pre[k][i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] m[$];
    rst_n        = 1'b0;
    msg_valid    = 1'b0;
    msg_data     = 32'h0;
    msg_last     = 1'b0;
    msg_nbytes   = 3'd0;
    digest_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_msg_ready", msg_ready, 0);
    check("rst_perm_start", perm_start, 0);
    check("rst_digest_valid", digest_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_digest0", digest[0], 32'h0);
    check("rst_digest7", digest[7], 32'h0);
    check("rst_state0", perm_state_in[0], 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_ready", msg_ready, 1);
    check("post_rst_busy", busy, 0);
    check("powerup_done_ignored", perm_state_in[5], 32'h0);

    // empty message
    m = {};
    run_msg(m, 0, 2, 0);
    if (pre_q.size() > 0) check("empty_pre0", pre_q[0][0], 32'h06000000);
    // "abc"
    m = {8'h61, 8'h62, 8'h63};
    run_msg(m, 0, 1, 0);
    if (pre_q.size() > 0) check("abc_pre0", pre_q[0][0], 32'h61626306);
    // eight full words 1..8: delimiter lands in a second block
    m = {};
    for (int i = 1; i <= 8; i++) begin
      m.push_back(8'h00); m.push_back(8'h00); m.push_back(8'h00); m.push_back(8'(i));
    end
    run_msg(m, 0, 0, 0);
    // 28 bytes: full last word at idx 6, delimiter goes in word 7
    m = {};
    for (int i = 0; i < 28; i++) m.push_back(8'($urandom));
    run_msg(m, 20, 1, 0);
    // 31 bytes: delimiter in the last byte of the block
    m = {};
    for (int i = 0; i < 31; i++) m.push_back(8'($urandom));
    run_msg(m, 0, 0, 0);
    // 9 words, last nbytes=2, valid held high through the permutation
    m = {};
    for (int i = 0; i < 34; i++) m.push_back(8'($urandom));
    run_msg(m, 0, 0, 0);
    // stale done through start and arm
    stale_mode = 1;
    m = {8'h61, 8'h62, 8'h63};
    run_msg(m, 0, 0, 0);
    m = {};
    for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
    run_msg(m, 0, 1, 0);
    stale_mode = 0;
    // illegal nbytes on a full last word behaves as 4
    m = {};
    for (int i = 0; i < 12; i++) m.push_back(8'($urandom));
    run_msg(m, 0, 0, 1);

    for (int t = 0; t < 20; t++) begin
      int len;
      m = {};
      len = int'($urandom_range(0, 100));
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      stale_mode = int'($urandom_range(0, 1));
      run_msg(m, (t % 2 == 0) ? 0 : 30, int'($urandom_range(0, 3)), (t % 5 == 4) ? 1 : 0);
    end
    stale_mode = 0;

    // reset while the engine runs, then a fresh "abc"
    lat_force = 12;
    pre_q.delete();
    start_cnt = 0;
    for (int i = 0; i < 8; i++) send_beat($urandom | 32'h1, 1'b0, 3'd4);
    msg_valid = 1'b0;
    for (int c = 0; c < 50 && !perm_start; c++) @(negedge clk);
    check("rst_test_start_seen", perm_start, 1);
    repeat (2) @(negedge clk);
    check("busy_in_wait", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_msg_ready", msg_ready, 0);
    check("midrst_perm_start", perm_start, 0);
    check("midrst_digest_valid", digest_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_state0", perm_state_in[0], 32'h0);
    check("midrst_digest0", digest[0], 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_ready_after", msg_ready, 1);
    lat_force = 0;
    repeat (15) @(negedge clk);
    check("stale_done_ignored_busy", busy, 0);
    check("stale_done_ignored_state", perm_state_in[0], 32'h0);
    check("stale_done_no_digest", digest_valid, 0);
    m = {8'h61, 8'h62, 8'h63};
    run_msg(m, 0, 5, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
